shift_left_seq: RTL and testbench



---
 rtl/shift_left_seq_if.sv | 12 +
 rtl/shift_left_seq.sv | 99 +++++++++
 tb/tb_shift_left_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_left_seq_if.sv
// Start/done handshake and operand/result bus for the iterative SLL unit.
interface shift_left_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] SLL;

  modport master (output start, A, B, input busy, done, SLL);
  modport slave  (input start, A, B, output busy, done, SLL);
endinterface

// File: rtl/shift_left_seq.sv
// Iterative logical left shifter (RV32 SLL/SLLI), STEP bits per SHIFT cycle.
// Optional macro SLL_FULL_B_EN: any B above 31 yields zero instead of using B[4:0].
module shift_left_seq #(
  parameter int unsigned STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_left_seq_if.slave  bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
      $error("shift_left_seq: STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [CNT_W-1:0]    count;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   sll_q;

  logic [CNT_W-1:0]    shamt_c;
  logic [CNT_W-1:0]    k_c;
  logic [DATA_W-1:0]   acc_next_c;
  logic                range_err_c;

  // Per-cycle shift amount is min(STEP, remaining count).
  always_comb begin
    shamt_c = bus.B[CNT_W-1:0];
`ifdef SLL_FULL_B_EN
    range_err_c = |bus.B[DATA_W-1:CNT_W];
`else
    range_err_c = 1'b0;
`endif
    k_c        = (count > CNT_W'(STEP)) ? CNT_W'(STEP) : count;
    acc_next_c = acc << k_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sll_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            acc    <= bus.A;
            count  <= shamt_c;
            // Zero shift and out-of-range amounts finish without a SHIFT cycle.
            if (range_err_c || (shamt_c == '0)) begin
              state  <= DONE;
              done_q <= 1'b1;
              sll_q  <= range_err_c ? '0 : bus.A;
            end else begin
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc   <= acc_next_c;
          count <= count - k_c;
          if (count <= CNT_W'(STEP)) begin
            state  <= DONE;
            done_q <= 1'b1;
            sll_q  <= acc_next_c;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.SLL  = sll_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: cycle-level reference model plus directed literal checks.
// Honours SLL_FULL_B_EN the same way the design does.
module tb_shift_left_seq;

  localparam int unsigned STEP = 1;

  logic clk = 1'b0;
  logic rst_n;

  shift_left_seq_if bus_if ();

  shift_left_seq #(.STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result = A << shamt, done appears ceil(shamt/STEP)+1 cycles after accept.
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  logic [31:0] m_sll   = '0;
  logic [31:0] m_pend  = '0;
  longint      cyc     = 0;
  longint      m_done_at = 0;

  always @(posedge clk) begin
    int unsigned shamt;
    int unsigned n;
    cyc++;
    if (rst_n !== 1'b1) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_sll   = '0;
    end else if (m_busy) begin
      if (m_done) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end else if (cyc == m_done_at) begin
        m_done = 1'b1;
        m_sll  = m_pend;
      end
    end else if (bus_if.start === 1'b1) begin
      shamt  = bus_if.B % 32;
      m_pend = bus_if.A << shamt;
      n      = (shamt + STEP - 1) / STEP;
`ifdef SLL_FULL_B_EN
      if (bus_if.B > 32'd31) begin
        m_pend = '0;
        n      = 0;
      end
`endif
      m_busy    = 1'b1;
      m_done_at = cyc + longint'(n);
      if (n == 0) begin
        m_done = 1'b1;
        m_sll  = m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", 32'(bus_if.busy), 32'(m_busy));
      chk("model_done", 32'(bus_if.done), 32'(m_done));
      chk("model_sll",  bus_if.SLL, m_sll);
    end
  end

  // Issue one request, measure cycles to done, return aligned to the cycle after done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                       input logic [31:0] exp_sll, input string name);
    int lat;
    bit seen;
    logic [31:0] got;
    bus_if.start = 1'b1;
    bus_if.A     = a;
    bus_if.B     = b;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.A     = $urandom;
    bus_if.B     = $urandom;
    lat  = 1;
    seen = 1'b0;
    got  = '0;
    while (lat <= 40 && !seen) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) begin
        seen = 1'b1;
        got  = bus_if.SLL;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_sll"}, got, exp_sll);
    @(posedge clk); #1;
  endtask

  initial begin
    int done_cnt;
    int done_cyc;
    logic [31:0] got;

    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.A     = '0;
    bus_if.B     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus_if.busy), 32'd0);
      chk("idle_done", 32'(bus_if.done), 32'd0);
      chk("idle_sll",  bus_if.SLL, 32'h0000_0000);
    end
    @(posedge clk); #1;

    do_op(32'h0000_0001, 32'd31, 32, 32'h8000_0000, "shift31");
    do_op(32'hDEAD_BEEF, 32'd0,  1,  32'hDEAD_BEEF, "shift0");
    do_op(32'hF000_0001, 32'd4,  5,  32'h0000_0010, "shift4_b2b");

    // Second start during SHIFT must be ignored.
    bus_if.start = 1'b1;
    bus_if.A     = 32'h1234_5678;
    bus_if.B     = 32'd8;
    done_cnt = 0;
    done_cyc = 0;
    got      = '0;
    for (int cur = 1; cur <= 14; cur++) begin
      @(posedge clk); #1;
      bus_if.start = (cur == 3);
      bus_if.A     = (cur == 3) ? 32'hFFFF_FFFF : 32'h0;
      bus_if.B     = (cur == 3) ? 32'd1 : 32'd0;
      @(negedge clk);
      if (bus_if.done === 1'b1) begin
        done_cnt++;
        done_cyc = cur;
        got      = bus_if.SLL;
      end
    end
    chk("ignore_done_count", 32'(done_cnt), 32'd1);
    chk("ignore_done_cycle", 32'(done_cyc), 32'd9);
    chk("ignore_sll", got, 32'h3456_7800);
    @(posedge clk); #1;

    // Reset in the middle of a long shift discards it.
    bus_if.start = 1'b1;
    bus_if.A     = 32'h0000_0001;
    bus_if.B     = 32'd31;
    done_cnt = 0;
    for (int cur = 1; cur <= 40; cur++) begin
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      rst_n = (cur != 10);
      @(negedge clk);
      if (bus_if.done === 1'b1) done_cnt++;
      if (cur == 11) begin
        chk("rst_mid_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_mid_sll",  bus_if.SLL, 32'h0000_0000);
      end
    end
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    do_op(32'h0000_0003, 32'd2, 3, 32'h0000_000C, "after_rst");

`ifdef SLL_FULL_B_EN
    do_op(32'h0000_0001, 32'd33, 1, 32'h0000_0000, "b33");
`else
    do_op(32'h0000_0001, 32'd33, 2, 32'h0000_0002, "b33");
`endif

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bus_if.start = ($urandom_range(0, 3) == 0);
      bus_if.A     = $urandom;
      bus_if.B     = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31));
      rst_n        = ($urandom_range(0, 299) != 0);
      @(posedge clk); #1;
    end
    rst_n        = 1'b1;
    bus_if.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
